stream_mux: RTL and testbench

STREAM_MUX -- requirements
Module: stream_mux

---
 rtl/stream_mux_if.sv | 27 ++
 rtl/stream_mux.sv | 105 ++++++++++
 tb/tb_stream_mux.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/stream_mux_if.sv
// Stream mux bus: N input channels, channel-select controls and one registered output.
// Master drives the inputs and consumes the output; slave is the mux side.
interface stream_mux_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = (N > 2) ? $clog2(N) : 1
);
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           force_en;
  logic [CW-1:0]  sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  out_chan;
  logic           out_ready;

  modport slave (
    input  in_valid, in_data, force_en, sel, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );

  modport master (
    output in_valid, in_data, force_en, sel, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/stream_mux.sv
// N-to-1 stream multiplexer with a single-entry registered output and forced/arbitrated select.
// STREAM_MUX_RR_EN: round-robin arbitration when defined, fixed lowest-index priority otherwise.
module stream_mux #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int CW = (N > 2) ? $clog2(N) : 1
) (
  input  logic       clk,
  input  logic       rst,
  stream_mux_if.slave bus
);

  logic [N-1:0]  elig;
  logic [N-1:0]  in_ready_c;
  logic [CW-1:0] grant;
  logic [W-1:0]  word;
  logic          hit;
  logic          load;
  int            idx;

  logic          vld_p1;
  logic [W-1:0]  data_p1;
  logic [CW-1:0] chan_p1;

`ifdef STREAM_MUX_RR_EN
  logic [CW-1:0] ptr;
`endif

  always_comb begin
    elig       = '0;
    grant      = '0;
    word       = '0;
    hit        = 1'b0;
    idx        = 0;
    in_ready_c = '0;

    // An out-of-range sel matches no channel, leaving nothing eligible.
    if (bus.force_en) begin
      for (int i = 0; i < N; i++)
        if (bus.sel == CW'(i)) elig[i] = bus.in_valid[i];
    end else begin
      elig = bus.in_valid;
    end

`ifdef STREAM_MUX_RR_EN
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!hit && elig[idx]) begin
        hit   = 1'b1;
        grant = CW'(idx);
      end
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (elig[i]) begin
        hit   = 1'b1;
        grant = CW'(i);
      end
    end
`endif

    for (int i = 0; i < N; i++)
      if (grant == CW'(i)) word = bus.in_data[i*W +: W];

    load = !rst && (!vld_p1 || bus.out_ready) && hit;

    if (load) begin
      for (int i = 0; i < N; i++)
        if (grant == CW'(i)) in_ready_c[i] = 1'b1;
    end
  end

  // Stage p1: output holding register
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      chan_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= word;
      chan_p1 <= grant;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

`ifdef STREAM_MUX_RR_EN
  // Forced transfers leave the rotation where it was.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load && !bus.force_en) begin
      ptr <= (grant == CW'(N - 1)) ? '0 : grant + 1'b1;
    end
  end
`endif

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = vld_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_chan  = chan_p1;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux: a 4-channel and a 3-channel instance sharing clock and reset.
module tb_stream_mux;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  stream_mux_if #(.N(4), .W(8)) bus4 ();
  stream_mux_if #(.N(3), .W(8)) bus3 ();

  stream_mux #(.N(4), .W(8)) u_mux4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  stream_mux #(.N(3), .W(8)) u_mux3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rr_chan [5];
  logic [3:0] exp_rdy;
  logic [7:0] exp_dat;
  logic [1:0] exp_chn;

  initial begin
    rst            = 1'b1;
    bus4.in_valid  = 4'b1111;
    bus4.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    bus4.force_en  = 1'b0;
    bus4.sel       = 2'd0;
    bus4.out_ready = 1'b1;
    bus3.in_valid  = 3'b000;
    bus3.in_data   = {8'h22, 8'h21, 8'h20};
    bus3.force_en  = 1'b0;
    bus3.sel       = 2'd0;
    bus3.out_ready = 1'b0;
    #1;

    // Reset: no ready while rst is high, cleared output afterwards
    for (int c = 0; c < 2; c++) begin
      chk("rst_in_ready", 32'(bus4.in_ready), 32'h0);
      step();
    end
    chk("rst_in_ready_end", 32'(bus4.in_ready), 32'h0);
    chk("rst_out_valid", 32'(bus4.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus4.out_data), 32'h00);
    chk("rst_out_chan", 32'(bus4.out_chan), 32'h0);
    chk("rst_out_valid3", 32'(bus3.out_valid), 32'h0);

    // Arbitration with all channels valid and downstream always ready
    rst = 1'b0;
`ifdef STREAM_MUX_RR_EN
    rr_chan = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
`else
    rr_chan = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
`endif
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("arb_in_ready", 32'(bus4.in_ready), 32'(4'b0001 << rr_chan[k]));
      step();
      chk("arb_out_valid", 32'(bus4.out_valid), 32'h1);
      chk("arb_out_chan", 32'(bus4.out_chan), 32'(rr_chan[k]));
      chk("arb_out_data", 32'(bus4.out_data), 32'(8'h10 + rr_chan[k]));
    end

    // Load A5 from channel 2 via forced select, then stall downstream
    bus4.in_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
    bus4.force_en = 1'b1;
    bus4.sel      = 2'd2;
    step();
    bus4.force_en  = 1'b0;
    bus4.out_ready = 1'b0;
    bus4.in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("hold_in_ready", 32'(bus4.in_ready), 32'h0);
      chk("hold_out_data", 32'(bus4.out_data), 32'hA5);
      chk("hold_out_chan", 32'(bus4.out_chan), 32'h2);
      chk("hold_out_valid", 32'(bus4.out_valid), 32'h1);
      step();
    end
    bus4.out_ready = 1'b1;
    #1;
`ifdef STREAM_MUX_RR_EN
    exp_rdy = 4'b0010;
    exp_dat = 8'h11;
    exp_chn = 2'd1;
`else
    exp_rdy = 4'b0001;
    exp_dat = 8'h10;
    exp_chn = 2'd0;
`endif
    chk("release_in_ready", 32'(bus4.in_ready), 32'(exp_rdy));
    step();
    chk("release_out_data", 32'(bus4.out_data), 32'(exp_dat));
    chk("release_out_chan", 32'(bus4.out_chan), 32'(exp_chn));

    // Forced select of channel 3 with channels 0 and 3 valid
    bus4.force_en = 1'b1;
    bus4.sel      = 2'd3;
    bus4.in_valid = 4'b1001;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("force_in_ready", 32'(bus4.in_ready), 32'h8);
      step();
      chk("force_out_chan", 32'(bus4.out_chan), 32'h3);
      chk("force_out_data", 32'(bus4.out_data), 32'h13);
    end

    // Three-channel instance: out-of-range sel blocks input, held word drains
    bus4.in_valid  = 4'b0000;
    bus3.force_en  = 1'b1;
    bus3.sel       = 2'd1;
    bus3.in_valid  = 3'b111;
    #1;
    chk("n3_load_in_ready", 32'(bus3.in_ready), 32'h2);
    step();
    chk("n3_load_out_valid", 32'(bus3.out_valid), 32'h1);
    chk("n3_load_out_data", 32'(bus3.out_data), 32'h21);
    bus3.sel = 2'd3;
    #1;
    chk("n3_oor_in_ready_stall", 32'(bus3.in_ready), 32'h0);
    step();
    chk("n3_oor_held", 32'(bus3.out_valid), 32'h1);
    bus3.out_ready = 1'b1;
    #1;
    chk("n3_oor_in_ready_drain", 32'(bus3.in_ready), 32'h0);
    step();
    chk("n3_drain_out_valid", 32'(bus3.out_valid), 32'h0);
    chk("n3_drain_out_data", 32'(bus3.out_data), 32'h21);
    chk("n3_drain_out_chan", 32'(bus3.out_chan), 32'h1);
    step();
    chk("n3_idle_out_valid", 32'(bus3.out_valid), 32'h0);

    // Advance the pointer to 2, stall, then pulse reset
    bus4.force_en  = 1'b0;
    bus4.in_valid  = 4'b0010;
    bus4.out_ready = 1'b1;
    step();
    chk("ptr_out_chan", 32'(bus4.out_chan), 32'h1);
    bus4.out_ready = 1'b0;
    bus4.in_valid  = 4'b1111;
    rst = 1'b1;
    #1;
    chk("pulse_in_ready", 32'(bus4.in_ready), 32'h0);
    step();
    rst = 1'b0;
    chk("pulse_out_valid", 32'(bus4.out_valid), 32'h0);
    bus4.out_ready = 1'b1;
    step();
    chk("post_rst_out_valid", 32'(bus4.out_valid), 32'h1);
    chk("post_rst_out_chan", 32'(bus4.out_chan), 32'h0);
    chk("post_rst_out_data", 32'(bus4.out_data), 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
